eth_mdio_master: RTL and testbench
==================================

Name: eth_mdio_master

Overview:
- IEEE 802.3 Clause 22 MDIO management master for the LAN8720 RMII PHY.
- Runs single read or write transactions on PHY registers after the PHY leaves hardware reset, e.g. polling BMSR (reg 1) for link-up or writing BMCR (reg 0).
- Sits in the 50 MHz clock domain beside the PHY reset generator.
- The MDIO tristate buffer sits at top level; this block exposes separate out, output-enable and in signals.

Parameters:
- CLK_DIV, 10: clk cycles per MDC half-period. MDC = clk / (2*CLK_DIV), which gives 2.5 MHz at 50 MHz. Legal values are 10 or greater.
- PREAMBLE_BITS, 32: number of leading '1' bits. Legal range is 0..32; 0 means preamble suppression.

Ports:
- clk  in  1  50 MHz system clock.
- rst  in  1  asynchronous reset, active high.
- start  in  1  request pulse; accepted only when busy=0.
- wr_en  in  1  1 = write, 0 = read; sampled on accept.
- phy_addr  in  5  PHYAD; sampled on accept.
- reg_addr  in  5  REGAD; sampled on accept.
- wr_data  in  16  write data; sampled on accept.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse at transaction end.
- rd_data  out  16  read result; valid from done until the next accept.
- rd_err  out  1  read turnaround error (no PHY answered); valid with done.
- mdc  out  1  management clock.
- mdio_o  out  1  MDIO output value.
- mdio_oe  out  1  MDIO output enable.
- mdio_i  in  1  MDIO input, pulled up at the pad.

Behaviour:
- Reset values: mdc=0, mdio_o=1, mdio_oe=0, busy=0, done=0, rd_data=0, rd_err=0, FSM in IDLE.
- Reset is asynchronous. Asserting it mid-frame aborts the frame immediately; no done pulse is produced.
- Accept: start=1 while busy=0 latches all request inputs. busy goes 1 on the next cycle. start while busy=1 is ignored and not queued.
- Frame: PREAMBLE_BITS x '1', then ST=01, then OP (read=10, write=01), then PHYAD[4:0] MSB first, then REGAD[4:0] MSB first, then TA, then DATA[15:0] MSB first.
  - Write TA = driven "10".
  - Read TA = first bit released (oe=0), second bit driven by the PHY.
- Bit period: 2*CLK_DIV cycles. First CLK_DIV cycles mdc=0 (low phase), last CLK_DIV cycles mdc=1 (high phase).
- Output timing: mdio_o/mdio_oe update on the first cycle of the low phase. PHY samples on the MDC rising edge.
- Read sampling: mdio_i is sampled on the clk cycle in which mdc goes 0->1, for the second TA bit and each data bit. Bit n is driven by the PHY after the rising edge of period n-1, giving ≥400 ns setup at CLK_DIV=10.
- mdio_oe: 1 during preamble/ST/OP/PHYAD/REGAD for reads. 1 for the whole frame for writes. 0 from the first TA bit of a read until the end of the frame.
- rd_err: set if the sampled second TA bit is 1. Data is still shifted in; with a pulled-up bus this gives rd_data=0xFFFF. rd_err=0 for writes.
- FSM states: IDLE, PREAMBLE, HEADER (ST/OP/PHYAD/REGAD, 14 bits), TURNAROUND (2 bits), DATA (16 bits), FINISH.
  - IDLE -> PREAMBLE on accept, or -> HEADER if PREAMBLE_BITS=0.
  - PREAMBLE, HEADER, TURNAROUND and DATA each advance after their last bit's high phase.
  - FINISH (1 cycle): mdc=0, mdio_oe=0, mdio_o=1, done=1, busy=0 on the following cycle, then -> IDLE.
- Latency: accept to done = 1 + (PREAMBLE_BITS+32)*2*CLK_DIV cycles, i.e. 1281 at defaults. A new start is accepted in the cycle after done.
- Idle bus: mdc stays low; mdio released (oe=0).
- Counters: bit counter 6 bits; divider counter sized to clog2(CLK_DIV). No wrap beyond 64 bits.

Decomposition:
- Package eth_mdio_pkg holds:
  - ST code 2'b01.
  - OP_READ 2'b10 and OP_WRITE 2'b01.
  - TA_WRITE 2'b10.
  - Header/TA/data bit-count constants.
  - FSM state enum.
- Sub-module eth_mdc_gen: divider producing mdc plus one-cycle strobes fall_stb (start of low phase) and rise_stb (0->1 cycle).
  - Held at phase 0 while the master is idle.
  - Restarts on accept.

Test Plan:
- Read PHY 0 reg 1; bus model returns TA=0 and data 0x782D -> rd_data=0x782D, rd_err=0, done exactly 1281 cycles after accept.
- Write PHY 0 reg 0 data 0x8000 -> captured serial stream is 32x'1' then 01 01 00000 00000 10 then 0x8000. mdio_oe=1 for all 64 bits.
- Read with no PHY (mdio_i held 1) -> rd_err=1, rd_data=0xFFFF, mdio_oe=0 for bits 46..63.
- start pulsed mid-transaction with different addr -> ignored. Only one done; latched phy_addr/reg_addr unchanged on the wire.
- rst asserted during DATA -> same cycle mdc=0, mdio_oe=0, busy=0, no done. A following read completes normally.
- CLK_DIV=10: MDC period 20 clk, 10 high/10 low. PREAMBLE_BITS=0: done 641 cycles after accept.

Source files
------------

// File: rtl/eth_mdio_pkg.sv
// ============================================================================
// Module  : eth_mdio_pkg
// Purpose : Clause 22 MDIO frame codes, field bit counts and master FSM states.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package eth_mdio_pkg;

    localparam logic [1:0] c_st       = 2'b01;
    localparam logic [1:0] c_op_read  = 2'b10;
    localparam logic [1:0] c_op_write = 2'b01;
    localparam logic [1:0] c_ta_write = 2'b10;

    localparam int c_hdr_bits  = 14;
    localparam int c_ta_bits   = 2;
    localparam int c_data_bits = 16;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PREAMBLE   = 3'd1,
        S_HEADER     = 3'd2,
        S_TURNAROUND = 3'd3,
        S_DATA       = 3'd4,
        S_FINISH     = 3'd5
    } mdio_state_e;

endpackage

`default_nettype wire

// File: rtl/eth_mdc_gen.sv
// ============================================================================
// Module  : eth_mdc_gen
// Purpose : MDC divider with strobes marking the start of the low phase and
//           the 0->1 transition cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_mdc_gen #(
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic mdc,
    output logic fall_stb,
    output logic rise_stb
);

    localparam int                 c_cnt_w    = $clog2(CLK_DIV);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_mdc;
    logic               w_wrap;

    assign w_wrap = en && (r_cnt == c_cnt_last);

    // Idle holds phase 0 so the first bit of a frame gets a full low phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_mdc <= 1'b0;
        end else if (!en || restart) begin
            r_cnt <= '0;
            r_mdc <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_mdc <= ~r_mdc;
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    assign mdc      = r_mdc;
    assign rise_stb = w_wrap && !r_mdc;
    assign fall_stb = w_wrap && r_mdc;

endmodule

`default_nettype wire

// File: rtl/eth_mdio_master.sv
// ============================================================================
// Module  : eth_mdio_master
// Purpose : IEEE 802.3 Clause 22 MDIO master, single read/write transactions.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_mdio_master
    import eth_mdio_pkg::*;
#(
    parameter int CLK_DIV       = 10,
    parameter int PREAMBLE_BITS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        wr_en,
    input  logic [4:0]  phy_addr,
    input  logic [4:0]  reg_addr,
    input  logic [15:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        rd_err,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    localparam logic [5:0] c_pre_last  = 6'(PREAMBLE_BITS - 1);
    localparam logic [5:0] c_hdr_last  = 6'(c_hdr_bits - 1);
    localparam logic [5:0] c_ta_last   = 6'(c_ta_bits - 1);
    localparam logic [5:0] c_data_last = 6'(c_data_bits - 1);

    mdio_state_e r_state, w_state_nxt;
    logic [5:0]  r_bit, w_bit_nxt;
    logic [31:0] r_tx, w_tx_nxt;
    logic [15:0] r_rx, w_rx_nxt;
    logic [15:0] r_rd_data, w_rd_data_nxt;
    logic        r_wr, w_wr_nxt;
    logic        r_mdio_o, w_mdio_o_nxt;
    logic        r_mdio_oe, w_mdio_oe_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;
    logic        r_rd_err, w_rd_err_nxt;

    logic        w_accept, w_run, w_mdc, w_fall, w_rise;
    logic [31:0] w_frame;

    assign w_accept = start && !r_busy;
    assign w_run    = (r_state == S_PREAMBLE) || (r_state == S_HEADER) ||
                      (r_state == S_TURNAROUND) || (r_state == S_DATA);
    // Everything after the preamble; for reads the TA/data part is never driven.
    assign w_frame  = {c_st, (wr_en ? c_op_write : c_op_read), phy_addr, reg_addr,
                       c_ta_write, wr_data};

    eth_mdc_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_mdc_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (w_run),
        .restart  (w_accept),
        .mdc      (w_mdc),
        .fall_stb (w_fall),
        .rise_stb (w_rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bit     <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rd_data <= '0;
            r_wr      <= 1'b0;
            r_mdio_o  <= 1'b1;
            r_mdio_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_err  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit     <= w_bit_nxt;
            r_tx      <= w_tx_nxt;
            r_rx      <= w_rx_nxt;
            r_rd_data <= w_rd_data_nxt;
            r_wr      <= w_wr_nxt;
            r_mdio_o  <= w_mdio_o_nxt;
            r_mdio_oe <= w_mdio_oe_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_rd_err  <= w_rd_err_nxt;
        end
    end

    // Outputs change on fall_stb, i.e. the first cycle of the next low phase.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_nxt     = r_bit;
        w_tx_nxt      = r_tx;
        w_rx_nxt      = r_rx;
        w_rd_data_nxt = r_rd_data;
        w_wr_nxt      = r_wr;
        w_mdio_o_nxt  = r_mdio_o;
        w_mdio_oe_nxt = r_mdio_oe;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_rd_err_nxt  = r_rd_err;
        case (r_state)
            S_IDLE: begin
                w_mdio_o_nxt  = 1'b1;
                w_mdio_oe_nxt = 1'b0;
                w_busy_nxt    = 1'b0;
                if (w_accept) begin
                    w_wr_nxt      = wr_en;
                    w_busy_nxt    = 1'b1;
                    w_rd_err_nxt  = 1'b0;
                    w_bit_nxt     = '0;
                    w_mdio_oe_nxt = 1'b1;
                    if (PREAMBLE_BITS == 0) begin
                        w_state_nxt  = S_HEADER;
                        w_mdio_o_nxt = w_frame[31];
                        w_tx_nxt     = {w_frame[30:0], 1'b1};
                    end else begin
                        w_state_nxt  = S_PREAMBLE;
                        w_tx_nxt     = w_frame;
                    end
                end
            end
            S_PREAMBLE: begin
                if (w_fall) begin
                    if (r_bit == c_pre_last) begin
                        w_state_nxt  = S_HEADER;
                        w_bit_nxt    = '0;
                        w_mdio_o_nxt = r_tx[31];
                        w_tx_nxt     = {r_tx[30:0], 1'b1};
                    end else begin
                        w_bit_nxt = r_bit + 6'd1;
                    end
                end
            end
            S_HEADER: begin
                if (w_fall) begin
                    w_mdio_o_nxt = r_tx[31];
                    w_tx_nxt     = {r_tx[30:0], 1'b1};
                    if (r_bit == c_hdr_last) begin
                        w_state_nxt   = S_TURNAROUND;
                        w_bit_nxt     = '0;
                        w_mdio_oe_nxt = r_wr;
                        if (!r_wr) w_mdio_o_nxt = 1'b1;
                    end else begin
                        w_bit_nxt = r_bit + 6'd1;
                    end
                end
            end
            S_TURNAROUND: begin
                // A PHY that answers pulls the second TA bit low.
                if (w_rise && !r_wr && (r_bit == c_ta_last)) w_rd_err_nxt = mdio_i;
                if (w_fall) begin
                    w_mdio_o_nxt = r_wr ? r_tx[31] : 1'b1;
                    w_tx_nxt     = {r_tx[30:0], 1'b1};
                    if (r_bit == c_ta_last) begin
                        w_state_nxt = S_DATA;
                        w_bit_nxt   = '0;
                    end else begin
                        w_bit_nxt = r_bit + 6'd1;
                    end
                end
            end
            S_DATA: begin
                if (w_rise && !r_wr) w_rx_nxt = {r_rx[14:0], mdio_i};
                if (w_fall) begin
                    if (r_bit == c_data_last) begin
                        w_state_nxt   = S_FINISH;
                        w_bit_nxt     = '0;
                        w_mdio_o_nxt  = 1'b1;
                        w_mdio_oe_nxt = 1'b0;
                        w_done_nxt    = 1'b1;
                        if (!r_wr) w_rd_data_nxt = r_rx;
                    end else begin
                        w_bit_nxt    = r_bit + 6'd1;
                        w_mdio_o_nxt = r_wr ? r_tx[31] : 1'b1;
                        w_tx_nxt     = {r_tx[30:0], 1'b1};
                    end
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign rd_data = r_rd_data;
    assign rd_err  = r_rd_err;
    assign mdc     = w_mdc;
    assign mdio_o  = r_mdio_o;
    assign mdio_oe = r_mdio_oe;

endmodule

`default_nettype wire

// File: tb/tb_eth_mdio_master.sv
// ============================================================================
// Module  : tb_eth_mdio_master
// Purpose : Self-checking bench for eth_mdio_master with a Clause 22 PHY model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eth_mdio_master;

    localparam int CLK_DIV = 10;
    localparam int PRE     = 32;
    localparam int LAT     = 1 + (PRE + 32) * 2 * CLK_DIV;
    localparam int LAT_NP  = 1 + 32 * 2 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst, start, wr_en, start_np;
    logic [4:0]  phy_addr, reg_addr;
    logic [15:0] wr_data;
    logic        busy, done, rd_err, mdc, mdio_o, mdio_oe, mdio_i;
    logic [15:0] rd_data;
    logic        busy_np, done_np, rd_err_np, mdc_np, mdio_o_np, mdio_oe_np;
    logic [15:0] rd_data_np;

    always #10 clk = ~clk;

    eth_mdio_master #(.CLK_DIV(CLK_DIV), .PREAMBLE_BITS(PRE)) dut (
        .clk(clk), .rst(rst), .start(start), .wr_en(wr_en), .phy_addr(phy_addr),
        .reg_addr(reg_addr), .wr_data(wr_data), .busy(busy), .done(done),
        .rd_data(rd_data), .rd_err(rd_err), .mdc(mdc), .mdio_o(mdio_o),
        .mdio_oe(mdio_oe), .mdio_i(mdio_i)
    );

    eth_mdio_master #(.CLK_DIV(CLK_DIV), .PREAMBLE_BITS(0)) dut_np (
        .clk(clk), .rst(rst), .start(start_np), .wr_en(wr_en), .phy_addr(phy_addr),
        .reg_addr(reg_addr), .wr_data(wr_data), .busy(busy_np), .done(done_np),
        .rd_data(rd_data_np), .rd_err(rd_err_np), .mdc(mdc_np), .mdio_o(mdio_o_np),
        .mdio_oe(mdio_oe_np), .mdio_i(1'b1)
    );

    // PHY model: records each bit at MDC rise, then drives the next read bit.
    logic        phy_present;
    logic [15:0] phy_data;
    logic        mdc_q;
    int          idx;
    logic [63:0] cap_o, cap_oe;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= 0;
            mdc_q  <= 1'b0;
            mdio_i <= 1'b1;
        end else begin
            mdc_q <= mdc;
            if (!busy) begin
                idx    <= 0;
                mdio_i <= 1'b1;
            end else if (mdc && !mdc_q) begin
                if (idx < 64) begin
                    cap_o[63-idx]  <= mdio_o;
                    cap_oe[63-idx] <= mdio_oe;
                end
                if (!phy_present)                        mdio_i <= 1'b1;
                else if (idx + 1 == 47)                  mdio_i <= 1'b0;
                else if (idx + 1 >= 48 && idx + 1 <= 63) mdio_i <= phy_data[62-idx];
                else                                     mdio_i <= 1'b1;
                idx <= idx + 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_frame(input logic wr, input logic [4:0] pa,
                                              input logic [4:0] ra, input logic [15:0] wd);
        return {32'hFFFF_FFFF, 2'b01, (wr ? 2'b01 : 2'b10), pa, ra, 2'b10, wd};
    endfunction

    task automatic run_txn(input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                           input logic [15:0] wd, input int glitch_at,
                           output int lat_o, output int r1, output int r2,
                           output int hi, output logic b1);
        logic mdc_prev;
        @(negedge clk);
        wr_en = wr; phy_addr = pa; reg_addr = ra; wr_data = wd; start = 1'b1;
        lat_o = 0; r1 = 0; r2 = 0; hi = 0; b1 = 1'b0; mdc_prev = 1'b0;
        for (int n = 1; n <= 4000; n++) begin
            @(negedge clk);
            start = (glitch_at != 0) && (n == glitch_at);
            if (start) begin
                phy_addr = ~pa; reg_addr = ~ra; wr_en = ~wr; wr_data = ~wd;
            end
            if (n == 1) b1 = busy;
            if (mdc && !mdc_prev) begin
                if (r1 == 0) r1 = n;
                else if (r2 == 0) r2 = n;
            end
            if (mdc && r1 != 0 && r2 == 0) hi++;
            mdc_prev = mdc;
            if (done) begin
                lat_o = n;
                break;
            end
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [4:0]  pa;
        logic [4:0]  ra;
        logic [15:0] wd;
        logic        present;
        logic [15:0] pdata;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        chk_rd;
        logic [15:0] rd;
        logic        err;
        int          lat;
    } exp_t;

    vec_t vecs[6];
    exp_t sbq[$];

    initial begin
        int   lat, r1, r2, hi, extra, n;
        logic b1;
        exp_t e;

        rst = 1'b1; start = 1'b0; start_np = 1'b0; wr_en = 1'b0;
        phy_addr = '0; reg_addr = '0; wr_data = '0;
        phy_present = 1'b1; phy_data = '0;
        repeat (3) @(negedge clk);
        check("reset mdc", 64'(mdc), 64'd0);
        check("reset mdio_o", 64'(mdio_o), 64'd1);
        check("reset mdio_oe", 64'(mdio_oe), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset rd_data", 64'(rd_data), 64'd0);
        check("reset rd_err", 64'(rd_err), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        vecs[0] = '{1'b0, 5'd0,  5'd1,  16'h0000, 1'b1, 16'h782D, 16'h782D, 1'b0};
        vecs[1] = '{1'b1, 5'd0,  5'd0,  16'h8000, 1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[2] = '{1'b0, 5'd1,  5'd2,  16'h0000, 1'b0, 16'h0000, 16'hFFFF, 1'b1};
        vecs[3] = '{1'b1, 5'h1F, 5'h1F, 16'h1234, 1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[4] = '{1'b0, 5'h1F, 5'h1F, 16'h0000, 1'b1, 16'hA5C3, 16'hA5C3, 1'b0};
        vecs[5] = '{1'b0, 5'h0A, 5'h05, 16'h0000, 1'b1, 16'h0001, 16'h0001, 1'b0};

        for (int i = 0; i < 6; i++) begin
            phy_present = vecs[i].present;
            phy_data    = vecs[i].pdata;
            sbq.push_back('{!vecs[i].wr, vecs[i].exp_rd, vecs[i].exp_err, LAT});
            run_txn(vecs[i].wr, vecs[i].pa, vecs[i].ra, vecs[i].wd, 0, lat, r1, r2, hi, b1);
            if (sbq.size() == 0) begin
                check("scoreboard empty", 64'd1, 64'd0);
                continue;
            end
            e = sbq.pop_front();
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(e.lat));
            if (e.chk_rd) check($sformatf("vec%0d rd_data", i), 64'(rd_data), 64'(e.rd));
            check($sformatf("vec%0d rd_err", i), 64'(rd_err), 64'(e.err));
            check($sformatf("vec%0d finish lines", i), {61'd0, mdc, mdio_oe, mdio_o}, 64'd1);
            check($sformatf("vec%0d finish busy", i), 64'(busy), 64'd1);
            if (vecs[i].wr) begin
                check($sformatf("vec%0d stream", i), cap_o,
                      exp_frame(1'b1, vecs[i].pa, vecs[i].ra, vecs[i].wd));
                check($sformatf("vec%0d oe", i), cap_oe, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check($sformatf("vec%0d header", i), 64'(cap_o[63:18]),
                      64'({32'hFFFF_FFFF, 2'b01, 2'b10, vecs[i].pa, vecs[i].ra}));
                check($sformatf("vec%0d oe", i), cap_oe, 64'hFFFF_FFFF_FFFC_0000);
            end
            if (i == 0) begin
                check("busy after accept", 64'(b1), 64'd1);
                check("first mdc rise", 64'(r1), 64'd11);
                check("mdc period", 64'(r2 - r1), 64'(2 * CLK_DIV));
                check("mdc high cycles", 64'(hi), 64'(CLK_DIV));
            end
            @(negedge clk);
            check($sformatf("vec%0d busy after done", i), 64'(busy), 64'd0);
        end

        // start pulsed mid-frame with inverted fields must not disturb the wire.
        phy_present = 1'b1;
        run_txn(1'b1, 5'h05, 5'h11, 16'hBEEF, 500, lat, r1, r2, hi, b1);
        check("glitch latency", 64'(lat), 64'(LAT));
        check("glitch stream", cap_o, exp_frame(1'b1, 5'h05, 5'h11, 16'hBEEF));
        extra = 0;
        repeat (1400) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("glitch extra done", 64'(extra), 64'd0);

        // Reset in the DATA phase of a read aborts without a done pulse.
        phy_data = 16'h1111;
        @(negedge clk);
        wr_en = 1'b0; phy_addr = 5'd0; reg_addr = 5'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (998) @(negedge clk);
        check("pre-abort busy", 64'(busy), 64'd1);
        check("pre-abort oe (data phase)", 64'(mdio_oe), 64'd0);
        rst = 1'b1;
        #1;
        check("abort lines", {60'd0, mdc, mdio_oe, busy, done}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (1400) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("abort no done", 64'(extra), 64'd0);
        phy_data = 16'h5A3C;
        run_txn(1'b0, 5'd0, 5'd1, 16'h0000, 0, lat, r1, r2, hi, b1);
        check("post-abort latency", 64'(lat), 64'(LAT));
        check("post-abort rd_data", 64'(rd_data), 64'h5A3C);
        check("post-abort rd_err", 64'(rd_err), 64'd0);

        // Preamble-suppressed instance, no PHY on its bus.
        @(negedge clk);
        wr_en = 1'b0; phy_addr = 5'd3; reg_addr = 5'd1; start_np = 1'b1;
        lat = 0;
        for (n = 1; n <= 2000; n++) begin
            @(negedge clk);
            start_np = 1'b0;
            if (done_np) begin
                lat = n;
                break;
            end
        end
        check("np latency", 64'(lat), 64'(LAT_NP));
        check("np rd_err", 64'(rd_err_np), 64'd1);
        check("np rd_data", 64'(rd_data_np), 64'hFFFF);
        check("np finish lines", {60'd0, busy_np, mdc_np, mdio_oe_np, mdio_o_np}, 64'b1001);
        @(negedge clk);
        check("np busy after done", 64'(busy_np), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
